// File: rtl/ql_vram_arbiter.sv
// SDRAM word-port arbiter for the QL: video fetch, microdrive emulation and CPU
// share one req/ack SDRAM port, with a timeout guard and video_cycle strobe.
module ql_vram_arbiter #(
    parameter int unsigned AW      = 19,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          vid_rd,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic          video_cycle,
    input  logic          mdv_men,
    input  logic          mdv_req,
    input  logic          mdv_we,
    input  logic [AW-1:0] mdv_addr,
    input  logic [DW-1:0] mdv_wdata,
    output logic          mdv_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] din,
    output logic          sd_req,
    output logic          sd_we,
    output logic [1:0]    sd_be,
    output logic [AW-1:0] sd_addr,
    output logic [DW-1:0] sd_wdata,
    input  logic          sd_ack,
    input  logic [DW-1:0] sd_rdata,
    output logic          err
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] G_VID = 2'd0;
    localparam logic [1:0] G_MDV = 2'd1;
    localparam logic [1:0] G_CPU = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [1:0]    r_grant;
    logic [1:0]    w_grant;
    logic          w_any;
    logic          w_mdv_ok;
    logic          w_timeout;
    logic          r_rr_last_cpu;
    logic [CW-1:0] r_cnt;

    // Winner selection and next state; video first, then mdv/cpu round-robin.
    always_comb begin
        w_next_state = r_state;
        w_grant      = G_VID;
        w_any        = 1'b0;
        w_mdv_ok     = mdv_req & mdv_men;
        w_timeout    = (r_cnt == CW'(TIMEOUT - 1));

        if (vid_rd) begin
            w_any   = 1'b1;
            w_grant = G_VID;
        end else if (w_mdv_ok && cpu_req) begin
            w_any   = 1'b1;
            w_grant = r_rr_last_cpu ? G_MDV : G_CPU;
        end else if (w_mdv_ok) begin
            w_any   = 1'b1;
            w_grant = G_MDV;
        end else if (cpu_req) begin
            w_any   = 1'b1;
            w_grant = G_CPU;
        end

        case (r_state)
            S_IDLE:  if (w_any) w_next_state = S_REQ;
            S_REQ:   if (sd_ack || w_timeout) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath and registered outputs; acks are high exactly during DONE.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_grant       <= G_VID;
            r_rr_last_cpu <= 1'b1;
            r_cnt         <= '0;
            vid_ack       <= 1'b0;
            mdv_ack       <= 1'b0;
            cpu_ack       <= 1'b0;
            video_cycle   <= 1'b0;
            din           <= '0;
            sd_req        <= 1'b0;
            sd_we         <= 1'b0;
            sd_be         <= 2'b00;
            sd_addr       <= '0;
            sd_wdata      <= '0;
            err           <= 1'b0;
        end else begin
            vid_ack <= 1'b0;
            mdv_ack <= 1'b0;
            cpu_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_grant;
                        r_cnt       <= '0;
                        sd_req      <= 1'b1;
                        video_cycle <= (w_grant == G_VID);
                        case (w_grant)
                            G_MDV: begin
                                sd_we         <= mdv_we;
                                sd_be         <= 2'b11;
                                sd_addr       <= mdv_addr;
                                sd_wdata      <= mdv_wdata;
                                r_rr_last_cpu <= 1'b0;
                            end
                            G_CPU: begin
                                sd_we         <= cpu_we;
                                sd_be         <= cpu_be;
                                sd_addr       <= cpu_addr;
                                sd_wdata      <= cpu_wdata;
                                r_rr_last_cpu <= 1'b1;
                            end
                            default: begin
                                sd_we    <= 1'b0;
                                sd_be    <= 2'b11;
                                sd_addr  <= vid_addr;
                                sd_wdata <= '0;
                            end
                        endcase
                    end
                end
                S_REQ: begin
                    if (sd_ack || w_timeout) begin
                        sd_req  <= 1'b0;
                        vid_ack <= (r_grant == G_VID);
                        mdv_ack <= (r_grant == G_MDV);
                        cpu_ack <= (r_grant == G_CPU);
                        if (sd_ack) begin
                            din <= sd_rdata;
                        end else begin
                            din <= {DW{1'b1}};
                            err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    video_cycle <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ql_vram_arbiter.sv
// Directed bench for ql_vram_arbiter: reset, priority, round-robin, mdv window,
// timeout and write command stability.
module tb_ql_vram_arbiter;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 16;
    localparam int unsigned TIMEOUT = 64;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          vid_rd;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic          video_cycle;
    logic          mdv_men;
    logic          mdv_req;
    logic          mdv_we;
    logic [AW-1:0] mdv_addr;
    logic [DW-1:0] mdv_wdata;
    logic          mdv_ack;
    logic          cpu_req;
    logic          cpu_we;
    logic [1:0]    cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] din;
    logic          sd_req;
    logic          sd_we;
    logic [1:0]    sd_be;
    logic [AW-1:0] sd_addr;
    logic [DW-1:0] sd_wdata;
    logic          sd_ack;
    logic [DW-1:0] sd_rdata;
    logic          err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_sys = ~clk_sys;

    ql_vram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_ack(vid_ack), .video_cycle(video_cycle),
        .mdv_men(mdv_men), .mdv_req(mdv_req), .mdv_we(mdv_we), .mdv_addr(mdv_addr),
        .mdv_wdata(mdv_wdata), .mdv_ack(mdv_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .din(din), .sd_req(sd_req), .sd_we(sd_we), .sd_be(sd_be), .sd_addr(sd_addr),
        .sd_wdata(sd_wdata), .sd_ack(sd_ack), .sd_rdata(sd_rdata), .err(err)
    );

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Bounded wait for sd_req; reports ticks taken and whether it was seen.
    task automatic wait_sd_req(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i <= budget; i++) begin
            if (sd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (i < budget) begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; vid_rd = 0; vid_addr = '0; mdv_men = 0; mdv_req = 0; mdv_we = 0;
        mdv_addr = '0; mdv_wdata = '0; cpu_req = 0; cpu_we = 0; cpu_be = 2'b00;
        cpu_addr = '0; cpu_wdata = '0; sd_ack = 0; sd_rdata = '0;
        tick(); tick();
        tests_run++;
        if ({sd_req, vid_ack, mdv_ack, cpu_ack, video_cycle, err, sd_we} !== 7'b0 ||
            din !== 16'h0 || sd_be !== 2'b00 || sd_addr !== 19'h0 || sd_wdata !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_values: sd_req=%b acks=%b%b%b vc=%b err=%b din=%h be=%b addr=%h, required all zero",
                     sd_req, vid_ack, mdv_ack, cpu_ack, video_cycle, err, din, sd_be, sd_addr);
        end
    endtask

    task automatic test_reset_mid_req();
        int acks;
        reset_n = 1'b1;
        tick();
        cpu_req = 1'b1; cpu_addr = 19'h00042;
        tick();
        cpu_req = 1'b0;
        tests_run++;
        if (sd_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL t1_grant: sd_req=%b, required 1", sd_req);
        end
        tick();
        reset_n = 1'b0;
        tick();
        tests_run++;
        if (sd_req !== 1'b0 || err !== 1'b0 || cpu_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_reset: sd_req=%b err=%b cpu_ack=%b, required 0 0 0", sd_req, err, cpu_ack);
        end
        reset_n = 1'b1;
        sd_ack = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            sd_ack = 1'b0;
            acks += int'(cpu_ack) + int'(vid_ack) + int'(mdv_ack) + int'(sd_req);
        end
        tests_run++;
        if (acks != 0) begin
            tests_failed++;
            $display("FAIL t1_no_ack: ack/req cycles=%0d, required 0", acks);
        end
    endtask

    task automatic test_video_priority();
        bit ok; int n;
        vid_rd = 1'b1; vid_addr = 19'h10000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 19'h00123;
        tick();
        vid_rd = 1'b0;
        tests_run++;
        if (sd_req !== 1'b1 || sd_addr !== 19'h10000 || video_cycle !== 1'b1 ||
            sd_we !== 1'b0 || sd_be !== 2'b11) begin
            tests_failed++;
            $display("FAIL t2_vid_grant: req=%b addr=%h vc=%b we=%b be=%b, required 1 10000 1 0 11",
                     sd_req, sd_addr, video_cycle, sd_we, sd_be);
        end
        tick();
        sd_ack = 1'b1; sd_rdata = 16'h1234;
        tick();
        sd_ack = 1'b0;
        tests_run++;
        if (vid_ack !== 1'b1 || cpu_ack !== 1'b0 || din !== 16'h1234 || video_cycle !== 1'b1) begin
            tests_failed++;
            $display("FAIL t2_vid_ack: vid_ack=%b cpu_ack=%b din=%h vc=%b, required 1 0 1234 1",
                     vid_ack, cpu_ack, din, video_cycle);
        end
        tick();
        tests_run++;
        if (vid_ack !== 1'b0 || video_cycle !== 1'b0 || sd_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL t2_idle: vid_ack=%b vc=%b sd_req=%b, required 0 0 0", vid_ack, video_cycle, sd_req);
        end
        wait_sd_req(4, ok, n);
        tests_run++;
        if (!ok || n != 1 || sd_addr !== 19'h00123 || video_cycle !== 1'b0) begin
            tests_failed++;
            $display("FAIL t2_cpu_grant: seen=%b ticks=%0d addr=%h vc=%b, required 1 1 00123 0",
                     ok, n, sd_addr, video_cycle);
        end
        cpu_req = 1'b0;
        sd_ack = 1'b1; sd_rdata = 16'hBEEF;
        tick();
        sd_ack = 1'b0;
        tests_run++;
        if (cpu_ack !== 1'b1 || din !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL t2_cpu_ack: cpu_ack=%b din=%h, required 1 beef", cpu_ack, din);
        end
        tick();
    endtask

    task automatic test_round_robin();
        bit ok; int n;
        logic [AW-1:0] exp_addr;
        logic [1:0]    exp_be;
        mdv_men = 1'b1; mdv_req = 1'b1; mdv_we = 1'b1; mdv_addr = 19'h00AAA; mdv_wdata = 16'h5A5A;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b01; cpu_addr = 19'h00CCC;
        for (int g = 0; g < 4; g++) begin
            exp_addr = (g % 2 == 0) ? 19'h00AAA : 19'h00CCC;
            exp_be   = (g % 2 == 0) ? 2'b11 : 2'b01;
            wait_sd_req(4, ok, n);
            tests_run++;
            if (!ok || sd_addr !== exp_addr || sd_be !== exp_be || sd_we !== (g % 2 == 0)) begin
                tests_failed++;
                $display("FAIL t3_grant%0d: seen=%b addr=%h be=%b we=%b, required 1 %h %b %b",
                         g, ok, sd_addr, sd_be, sd_we, exp_addr, exp_be, (g % 2 == 0));
            end
            tick();
            sd_ack = 1'b1; sd_rdata = 16'(g);
            tick();
            sd_ack = 1'b0;
            tests_run++;
            if (mdv_ack !== (g % 2 == 0) || cpu_ack !== (g % 2 == 1) || din !== 16'(g)) begin
                tests_failed++;
                $display("FAIL t3_ack%0d: mdv_ack=%b cpu_ack=%b din=%h, required %b %b %h",
                         g, mdv_ack, cpu_ack, din, (g % 2 == 0), (g % 2 == 1), 16'(g));
            end
            tick();
        end
        mdv_req = 1'b0; cpu_req = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_mdv_window();
        bit ok; int n; int reqs;
        mdv_men = 1'b0; mdv_req = 1'b1; mdv_we = 1'b0; mdv_addr = 19'h00777;
        reqs = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            reqs += int'(sd_req);
        end
        tests_run++;
        if (reqs != 0) begin
            tests_failed++;
            $display("FAIL t4_closed: sd_req cycles=%0d, required 0", reqs);
        end
        mdv_men = 1'b1;
        wait_sd_req(2, ok, n);
        tests_run++;
        if (!ok || sd_addr !== 19'h00777) begin
            tests_failed++;
            $display("FAIL t4_open: seen=%b ticks=%0d addr=%h, required seen within 2, addr 00777", ok, n, sd_addr);
        end
        mdv_req = 1'b0;
        mdv_men = 1'b0;
        tick();
        sd_ack = 1'b1; sd_rdata = 16'h0777;
        tick();
        sd_ack = 1'b0;
        tests_run++;
        if (mdv_ack !== 1'b1 || din !== 16'h0777) begin
            tests_failed++;
            $display("FAIL t4_ack: mdv_ack=%b din=%h, required 1 0777", mdv_ack, din);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n; bit seen;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 19'h00321;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            cpu_req = 1'b0;
            if (cpu_ack === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!seen || n != TIMEOUT + 1) begin
            tests_failed++;
            $display("FAIL t5_latency: seen=%b cycles=%0d, required 1 %0d", seen, n, TIMEOUT + 1);
        end
        tests_run++;
        if (din !== 16'hFFFF || err !== 1'b1 || sd_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL t5_result: din=%h err=%b sd_req=%b, required ffff 1 0", din, err, sd_req);
        end
        tick(); tick(); tick();
        tests_run++;
        if (err !== 1'b1 || cpu_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL t5_sticky: err=%b cpu_ack=%b, required 1 0", err, cpu_ack);
        end
    endtask

    task automatic test_cpu_write();
        int bad;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b10; cpu_addr = 19'h14000; cpu_wdata = 16'hA55A;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b01; cpu_addr = 19'h00000; cpu_wdata = 16'h0000;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (sd_req !== 1'b1 || sd_we !== 1'b1 || sd_be !== 2'b10 ||
                sd_addr !== 19'h14000 || sd_wdata !== 16'hA55A) bad++;
            if (i < 3) tick();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL t6_cmd_hold: bad cycles=%0d (we=%b be=%b addr=%h wdata=%h), required 0 (1 10 14000 a55a)",
                     bad, sd_we, sd_be, sd_addr, sd_wdata);
        end
        sd_ack = 1'b1; sd_rdata = 16'h0F0F;
        tick();
        sd_ack = 1'b0;
        tests_run++;
        if (cpu_ack !== 1'b1 || sd_req !== 1'b0 || din !== 16'h0F0F) begin
            tests_failed++;
            $display("FAIL t6_ack: cpu_ack=%b sd_req=%b din=%h, required 1 0 0f0f", cpu_ack, sd_req, din);
        end
        tick();
    endtask

    task automatic test_stray_ack();
        sd_ack = 1'b1; sd_rdata = 16'hDEAD;
        tick();
        sd_ack = 1'b0;
        tick();
        tests_run++;
        if ({vid_ack, mdv_ack, cpu_ack, sd_req} !== 4'b0 || din !== 16'h0F0F) begin
            tests_failed++;
            $display("FAIL stray_ack: acks=%b%b%b sd_req=%b din=%h, required 000 0 0f0f",
                     vid_ack, mdv_ack, cpu_ack, sd_req, din);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tests_run++;
        if (err !== 1'b0 || din !== 16'h0) begin
            tests_failed++;
            $display("FAIL err_clear: err=%b din=%h, required 0 0000", err, din);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_req();
        test_video_priority();
        test_round_robin();
        test_mdv_window();
        test_timeout();
        test_cpu_write();
        test_stray_ack();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
